// File: rtl/stconv_pkg.sv
// Shared constants for the store converter: RISC-V STORE opcode, store funct3 codes
// and the controller state encoding.
package stconv_pkg;

    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [2:0] F3_SB     = 3'b000;
    localparam logic [2:0] F3_SH     = 3'b001;
    localparam logic [2:0] F3_SW     = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR0,
        ST_WR1,
        ST_RESP
    } state_t;

    function automatic logic is_legal_store(input logic [6:0] opcode, input logic [2:0] funct3);
        return (opcode == OPC_STORE) &&
               ((funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW));
    endfunction

endpackage

// File: rtl/stconv_align.sv
// Combinational lane aligner: masks store data to its width and shifts data and
// byte enables across a two-word window so a word-crossing store shows up in the upper half.
module stconv_align
    import stconv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] data,
    output logic [63:0] wide,
    output logic [7:0]  bew
);

    logic [31:0] masked;
    logic [3:0]  be;

    always_comb begin
        masked = '0;
        be     = '0;
        case (funct3)
            F3_SB: begin
                masked = {24'h0, data[7:0]};
                be     = 4'b0001;
            end
            F3_SH: begin
                masked = {16'h0, data[15:0]};
                be     = 4'b0011;
            end
            F3_SW: begin
                masked = data;
                be     = 4'b1111;
            end
            default: begin
                masked = '0;
                be     = '0;
            end
        endcase
        wide = {32'h0, masked} << {offset, 3'b000};
        bew  = {4'h0, be} << offset;
    end

endmodule

// File: rtl/stconv_ctrl.sv
// Store converter controller: captures one store, aligns it, and issues one or two
// word-aligned beats on a req/ack write port before pulsing done.
module stconv_ctrl
    import stconv_pkg::*;
#(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] ir,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    output logic        done,
    output logic        err,
    output logic        misalign
);

    state_t      state, state_n;
    logic [6:0]  opc_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, data_q;

    logic [6:0]  cur_opc;
    logic [2:0]  cur_f3;
    logic [31:0] cur_addr, cur_data, base_addr;
    logic [63:0] wide;
    logic [7:0]  bew;
    logic        legal, crossing;

    logic        req_q, req_n, done_q, done_n, err_q, err_n, mis_q, mis_n;
    logic [31:0] maddr_q, maddr_n, wdata_q, wdata_n;
    logic [3:0]  we_q, we_n;

    logic        unused_ir_bits;
    assign unused_ir_bits = ^{ir[31:15], ir[11:7]};

    // In IDLE decode straight from the inputs so the first beat issues on the accept edge.
    assign cur_opc   = (state == ST_IDLE) ? ir[6:0]   : opc_q;
    assign cur_f3    = (state == ST_IDLE) ? ir[14:12] : f3_q;
    assign cur_addr  = (state == ST_IDLE) ? addr      : addr_q;
    assign cur_data  = (state == ST_IDLE) ? data      : data_q;
    assign base_addr = {cur_addr[31:2], 2'b00};

    stconv_align u_align (
        .funct3 (cur_f3),
        .offset (cur_addr[1:0]),
        .data   (cur_data),
        .wide   (wide),
        .bew    (bew)
    );

    assign legal    = is_legal_store(cur_opc, cur_f3);
    assign crossing = |bew[7:4];

    always_comb begin
        state_n = state;
        req_n   = req_q;
        maddr_n = maddr_q;
        wdata_n = wdata_q;
        we_n    = we_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        mis_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (!legal) begin
                        state_n = ST_RESP;
                        done_n  = 1'b1;
                        err_n   = 1'b1;
                    end else if (crossing && !SPLIT_EN) begin
                        state_n = ST_RESP;
                        done_n  = 1'b1;
                        mis_n   = 1'b1;
                    end else begin
                        state_n = ST_WR0;
                        req_n   = 1'b1;
                        maddr_n = base_addr;
                        wdata_n = wide[31:0];
                        we_n    = bew[3:0];
                    end
                end
            end
            ST_WR0: begin
                if (mem_ack) begin
                    req_n = 1'b0;
                    we_n  = '0;
                    if (crossing) begin
                        state_n = ST_WR1;
                    end else begin
                        state_n = ST_RESP;
                        done_n  = 1'b1;
                    end
                end
            end
            ST_WR1: begin
                // First WR1 cycle keeps mem_req low so the second beat is a fresh request.
                if (!req_q) begin
                    req_n   = 1'b1;
                    maddr_n = base_addr + 32'd4;
                    wdata_n = wide[63:32];
                    we_n    = bew[7:4];
                end else if (mem_ack) begin
                    req_n   = 1'b0;
                    we_n    = '0;
                    state_n = ST_RESP;
                    done_n  = 1'b1;
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                req_n   = 1'b0;
                we_n    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            opc_q   <= '0;
            f3_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            req_q   <= 1'b0;
            maddr_q <= '0;
            wdata_q <= '0;
            we_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state   <= state_n;
            req_q   <= req_n;
            maddr_q <= maddr_n;
            wdata_q <= wdata_n;
            we_q    <= we_n;
            done_q  <= done_n;
            err_q   <= err_n;
            mis_q   <= mis_n;
            if (state == ST_IDLE && req_valid) begin
                opc_q  <= ir[6:0];
                f3_q   <= ir[14:12];
                addr_q <= addr;
                data_q <= data;
            end
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign mem_req   = req_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign done      = done_q;
    assign err       = err_q;
    assign misalign  = mis_q;

endmodule

// File: tb/tb_stconv_ctrl.sv
// Self-checking bench for stconv_ctrl: directed cases plus randomized stores checked
// against a byte-by-byte reference model; a second instance runs with splitting disabled.
module tb_stconv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_valid0 = 1'b0;
    logic [31:0] ir = '0, addr = '0, data = '0;
    logic        mem_ack = 1'b0;

    logic        req_ready, mem_req, done, err, misalign;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_we;
    logic        req_ready0, mem_req0, done0, err0, misalign0;
    logic [31:0] mem_addr0, mem_wdata0;
    logic [3:0]  mem_we0;

    int checks = 0;
    int fails  = 0;

    // Observations gathered by drive_store for the test tasks to judge.
    int               obs_nb, obs_done, obs_done_cyc, obs_gap;
    logic             obs_err, obs_mis, obs_unstable, obs_ready_after;
    logic [1:0][31:0] obs_addr, obs_wdata;
    logic [1:0][3:0]  obs_we;

    always #5 clk = ~clk;

    stconv_ctrl #(.SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .ir(ir), .addr(addr), .data(data), .mem_req(mem_req), .mem_ack(mem_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .done(done), .err(err), .misalign(misalign)
    );

    stconv_ctrl #(.SPLIT_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
        .ir(ir), .addr(addr), .data(data), .mem_req(mem_req0), .mem_ack(mem_ack),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_we(mem_we0),
        .done(done0), .err(err0), .misalign(misalign0)
    );

    function automatic logic [31:0] mk_ir(input logic [2:0] f3, input logic [6:0] opc);
        return {17'h0, f3, 5'h0, opc};
    endfunction

    // Reference: walk the stored bytes one at a time and place each in its word/lane.
    function automatic void model(input logic [31:0] m_ir, m_addr, m_data, input bit split,
                                  output int nb, output logic [1:0][31:0] ea,
                                  output logic [1:0][31:0] ew, output logic [1:0][3:0] ewe,
                                  output logic eerr, output logic emis);
        int size;
        logic [2:0]  f3;
        logic [31:0] ba;
        int idx, lane;
        f3 = m_ir[14:12];
        nb = 0; ea = '0; ew = '0; ewe = '0; eerr = 1'b0; emis = 1'b0;
        if (m_ir[6:0] != 7'b0100011 || f3 > 3'd2) begin
            eerr = 1'b1;
            return;
        end
        size = 1 << f3;
        if (int'(m_addr[1:0]) + size > 4 && !split) begin
            emis = 1'b1;
            return;
        end
        nb = (int'(m_addr[1:0]) + size > 4) ? 2 : 1;
        ea[0] = m_addr & 32'hFFFF_FFFC;
        ea[1] = ea[0] + 32'd4;
        for (int k = 0; k < size; k++) begin
            ba   = m_addr + k;
            idx  = ((ba >> 2) == (m_addr >> 2)) ? 0 : 1;
            lane = int'(ba[1:0]);
            ewe[idx][lane] = 1'b1;
            ew[idx][8*lane +: 8] = m_data[8*k +: 8];
        end
    endfunction

    // Drives one store into the selected instance and acts as the memory, acking each
    // beat after ack_wait request cycles. Ends one cycle after done (or on timeout).
    task automatic drive_store(input logic [31:0] t_ir, t_addr, t_data,
                               input int ack_wait, input bit use0);
        int bw, low_run, k;
        bit in_gap;
        logic req_s, done_s, rdy_s;
        logic [31:0] a_s, w_s, cur_a, cur_w;
        logic [3:0] we_s, cur_we;
        obs_nb = 0; obs_done = 0; obs_done_cyc = 0; obs_gap = -1;
        obs_err = 1'b0; obs_mis = 1'b0; obs_unstable = 1'b0; obs_ready_after = 1'b0;
        obs_addr = '0; obs_wdata = '0; obs_we = '0;
        cur_a = '0; cur_w = '0; cur_we = '0;
        k = 0;
        while (!(use0 ? req_ready0 : req_ready) && k < 20) begin
            @(posedge clk); #1; k++;
        end
        ir = t_ir; addr = t_addr; data = t_data;
        if (use0) req_valid0 = 1'b1; else req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_valid0 = 1'b0;
        bw = 0; in_gap = 0; low_run = 0;
        for (int c = 1; c <= 60; c++) begin
            req_s  = use0 ? mem_req0   : mem_req;
            a_s    = use0 ? mem_addr0  : mem_addr;
            w_s    = use0 ? mem_wdata0 : mem_wdata;
            we_s   = use0 ? mem_we0    : mem_we;
            done_s = use0 ? done0      : done;
            rdy_s  = use0 ? req_ready0 : req_ready;
            if (!req_s && we_s != 4'h0) obs_unstable = 1'b1;
            if (done_s) begin
                obs_done++;
                if (obs_done == 1) begin
                    obs_done_cyc = c;
                    obs_err = use0 ? err0 : err;
                    obs_mis = use0 ? misalign0 : misalign;
                end
            end
            if (req_s) begin
                if (bw == 0) begin
                    cur_a = a_s; cur_w = w_s; cur_we = we_s;
                    if (in_gap) obs_gap = low_run;
                end else if ({a_s, w_s, we_s} !== {cur_a, cur_w, cur_we}) begin
                    obs_unstable = 1'b1;
                end
                if (bw >= ack_wait) begin
                    mem_ack = 1'b1;
                    if (obs_nb < 2) begin
                        obs_addr[obs_nb] = a_s; obs_wdata[obs_nb] = w_s; obs_we[obs_nb] = we_s;
                    end
                    obs_nb++;
                    bw = 0; in_gap = 1; low_run = 0;
                end else begin
                    mem_ack = 1'b0;
                    bw++;
                end
            end else begin
                mem_ack = 1'b0;
                if (in_gap) low_run++;
            end
            if (obs_done_cyc != 0 && c == obs_done_cyc + 1) begin
                obs_ready_after = rdy_s;
                break;
            end
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mem_req, mem_we, done, err, misalign} !== 8'h00) begin
            fails++;
            $display("[TB] FAIL reset_ctrl actual=%b required=00000000", {mem_req, mem_we, done, err, misalign});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            fails++;
            $display("[TB] FAIL reset_data actual=%h/%h required=0/0", mem_addr, mem_wdata);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || req_ready0 !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_ready actual=%b%b required=11", req_ready, req_ready0);
        end
    endtask

    task automatic test_sw_aligned();
        drive_store(mk_ir(3'b010, 7'b0100011), 32'h100, 32'hDEADBEEF, 0, 0);
        checks++;
        if (obs_nb !== 1 || {obs_addr[0], obs_we[0], obs_wdata[0]} !== {32'h100, 4'hF, 32'hDEADBEEF}) begin
            fails++;
            $display("[TB] FAIL sw_beat actual=%0d %h %b %h required=1 00000100 1111 deadbeef",
                     obs_nb, obs_addr[0], obs_we[0], obs_wdata[0]);
        end
        checks++;
        if (obs_done !== 1 || obs_done_cyc !== 2 || obs_err !== 1'b0 || obs_mis !== 1'b0) begin
            fails++;
            $display("[TB] FAIL sw_done actual=cnt%0d cyc%0d e%b m%b required=cnt1 cyc2 e0 m0",
                     obs_done, obs_done_cyc, obs_err, obs_mis);
        end
        checks++;
        if (obs_ready_after !== 1'b1 || obs_unstable !== 1'b0) begin
            fails++;
            $display("[TB] FAIL sw_ready actual=rdy%b unst%b required=rdy1 unst0", obs_ready_after, obs_unstable);
        end
    endtask

    task automatic test_sub_word();
        drive_store(mk_ir(3'b000, 7'b0100011), 32'h203, 32'h123456A5, 1, 0);
        checks++;
        if (obs_nb !== 1 || {obs_addr[0], obs_we[0], obs_wdata[0]} !== {32'h200, 4'b1000, 32'hA5000000}) begin
            fails++;
            $display("[TB] FAIL sb_beat actual=%0d %h %b %h required=1 00000200 1000 a5000000",
                     obs_nb, obs_addr[0], obs_we[0], obs_wdata[0]);
        end
        drive_store(mk_ir(3'b001, 7'b0100011), 32'h302, 32'hFFFF8001, 0, 0);
        checks++;
        if (obs_nb !== 1 || {obs_addr[0], obs_we[0], obs_wdata[0]} !== {32'h300, 4'b1100, 32'h80010000}) begin
            fails++;
            $display("[TB] FAIL sh_beat actual=%0d %h %b %h required=1 00000300 1100 80010000",
                     obs_nb, obs_addr[0], obs_we[0], obs_wdata[0]);
        end
    endtask

    task automatic test_split();
        drive_store(mk_ir(3'b010, 7'b0100011), 32'h401, 32'h11223344, 0, 0);
        checks++;
        if (obs_nb !== 2 || {obs_addr[0], obs_we[0], obs_wdata[0]} !== {32'h400, 4'b1110, 32'h22334400}) begin
            fails++;
            $display("[TB] FAIL split_beat0 actual=%0d %h %b %h required=2 00000400 1110 22334400",
                     obs_nb, obs_addr[0], obs_we[0], obs_wdata[0]);
        end
        checks++;
        if ({obs_addr[1], obs_we[1], obs_wdata[1]} !== {32'h404, 4'b0001, 32'h00000011}) begin
            fails++;
            $display("[TB] FAIL split_beat1 actual=%h %b %h required=00000404 0001 00000011",
                     obs_addr[1], obs_we[1], obs_wdata[1]);
        end
        checks++;
        if (obs_done !== 1 || obs_gap !== 1 || obs_err !== 1'b0 || obs_mis !== 1'b0 || obs_unstable !== 1'b0) begin
            fails++;
            $display("[TB] FAIL split_done actual=cnt%0d gap%0d e%b m%b u%b required=cnt1 gap1 e0 m0 u0",
                     obs_done, obs_gap, obs_err, obs_mis, obs_unstable);
        end
    endtask

    task automatic test_wrap();
        drive_store(mk_ir(3'b010, 7'b0100011), 32'hFFFFFFFE, 32'hCAFEF00D, 0, 0);
        checks++;
        if (obs_nb !== 2 || {obs_addr[0], obs_we[0]} !== {32'hFFFFFFFC, 4'b1100} ||
            {obs_addr[1], obs_we[1], obs_wdata[1]} !== {32'h0, 4'b0011, 32'h0000CAFE}) begin
            fails++;
            $display("[TB] FAIL wrap_beats actual=%0d %h %b %h %b %h required=2 fffffffc 1100 00000000 0011 0000cafe",
                     obs_nb, obs_addr[0], obs_we[0], obs_addr[1], obs_we[1], obs_wdata[1]);
        end
        drive_store(mk_ir(3'b010, 7'b0100011), 32'hFFFFFFFE, 32'hCAFEF00D, 0, 1);
        checks++;
        if (obs_nb !== 0 || obs_done !== 1 || obs_mis !== 1'b1 || obs_err !== 1'b0 || obs_done_cyc !== 1) begin
            fails++;
            $display("[TB] FAIL nosplit_misalign actual=nb%0d cnt%0d m%b e%b cyc%0d required=nb0 cnt1 m1 e0 cyc1",
                     obs_nb, obs_done, obs_mis, obs_err, obs_done_cyc);
        end
    endtask

    task automatic test_illegal();
        drive_store(mk_ir(3'b010, 7'b0000011), 32'h600, 32'h55AA55AA, 0, 0);
        checks++;
        if (obs_nb !== 0 || obs_done !== 1 || obs_err !== 1'b1 || obs_mis !== 1'b0 || obs_ready_after !== 1'b1) begin
            fails++;
            $display("[TB] FAIL illegal_err actual=nb%0d cnt%0d e%b m%b rdy%b required=nb0 cnt1 e1 m0 rdy1",
                     obs_nb, obs_done, obs_err, obs_mis, obs_ready_after);
        end
    endtask

    task automatic test_idle_ack();
        bit bad;
        bad = 1'b0;
        mem_ack = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (mem_req !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
        end
        mem_ack = 1'b0;
        checks++;
        if (bad) begin
            fails++;
            $display("[TB] FAIL idle_ack actual=activity required=none");
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        saw_done = 1'b0;
        ir = mk_ir(3'b010, 7'b0100011); addr = 32'h500; data = 32'h01020304;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (mem_req !== 1'b1) begin
            fails++;
            $display("[TB] FAIL rstmid_req actual=%b required=1", mem_req);
        end
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 4'h0) begin
            fails++;
            $display("[TB] FAIL rstmid_async actual=%b %b required=0 0000", mem_req, mem_we);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (done !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done || req_ready !== 1'b1 || mem_req !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rstmid_after actual=done%b rdy%b req%b required=done0 rdy1 req0",
                     saw_done, req_ready, mem_req);
        end
    endtask

    task automatic test_random();
        logic [31:0] r_ir, r_addr, r_data;
        logic [2:0] f3;
        bit use0;
        int ack_wait, enb;
        logic [1:0][31:0] ea, ew;
        logic [1:0][3:0] ewe;
        logic eerr, emis;
        for (int n = 0; n < 60; n++) begin
            f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            r_ir = $urandom;
            r_ir[14:12] = f3;
            if ($urandom_range(0, 9) != 0) r_ir[6:0] = 7'b0100011;
            r_addr = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3))) : $urandom;
            r_data = $urandom;
            use0 = ($urandom_range(0, 3) == 0);
            ack_wait = $urandom_range(0, 2);
            model(r_ir, r_addr, r_data, !use0, enb, ea, ew, ewe, eerr, emis);
            drive_store(r_ir, r_addr, r_data, ack_wait, use0);
            checks++;
            if (obs_nb !== enb || obs_done !== 1 || obs_err !== eerr || obs_mis !== emis) begin
                fails++;
                $display("[TB] FAIL rand_status n=%0d actual=nb%0d cnt%0d e%b m%b required=nb%0d cnt1 e%b m%b",
                         n, obs_nb, obs_done, obs_err, obs_mis, enb, eerr, emis);
            end
            for (int b = 0; b < enb; b++) begin
                checks++;
                if ({obs_addr[b], obs_we[b], obs_wdata[b]} !== {ea[b], ewe[b], ew[b]}) begin
                    fails++;
                    $display("[TB] FAIL rand_beat n=%0d b=%0d actual=%h %b %h required=%h %b %h",
                             n, b, obs_addr[b], obs_we[b], obs_wdata[b], ea[b], ewe[b], ew[b]);
                end
            end
            checks++;
            if (obs_unstable !== 1'b0 || obs_ready_after !== 1'b1 ||
                (enb == 2 && obs_gap !== 1) ||
                (enb == 0 && obs_done_cyc !== 1) ||
                (enb == 1 && ack_wait == 0 && obs_done_cyc !== 2)) begin
                fails++;
                $display("[TB] FAIL rand_timing n=%0d actual=u%b rdy%b gap%0d cyc%0d required=u0 rdy1 (nb=%0d aw=%0d)",
                         n, obs_unstable, obs_ready_after, obs_gap, obs_done_cyc, enb, ack_wait);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sw_aligned();
        test_sub_word();
        test_split();
        test_wrap();
        test_illegal();
        test_idle_ack();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
